// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared constants for the instruction-decode stage.
//   - IF/ID bundle field offsets (HALT_BIT, PC_HI, PC_LO)
//   - ID/EX bundle field offsets and IDEX_W
//   - ctrl bit positions, opcode/funct constants, ALU_* encodings
//   - RUN/HALT state type and a sign-extension helper
package id_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;

  // IF/ID bundle: {halt, pc[31:0], inst[31:0]}
  localparam int unsigned IFID_W   = 65;
  localparam int unsigned HALT_BIT = 64;
  localparam int unsigned PC_HI    = 63;
  localparam int unsigned PC_LO    = 32;

  // ID/EX bundle: halt, pc, rs_val, rt_val, imm, rs, rt, rd, ctrl
  localparam int unsigned CTRL_W       = 12;
  localparam int unsigned IDEX_W       = 156;
  localparam int unsigned IDEX_HALT    = 155;
  localparam int unsigned IDEX_PC_LO   = 123;
  localparam int unsigned IDEX_RSV_LO  = 91;
  localparam int unsigned IDEX_RTV_LO  = 59;
  localparam int unsigned IDEX_IMM_LO  = 27;
  localparam int unsigned IDEX_RS_LO   = 22;
  localparam int unsigned IDEX_RT_LO   = 17;
  localparam int unsigned IDEX_RD_LO   = 12;
  localparam int unsigned IDEX_CTRL_LO = 0;

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, jump, alu_op[3:0]}
  localparam int unsigned CTRL_REG_WRITE  = 11;
  localparam int unsigned CTRL_MEM_READ   = 10;
  localparam int unsigned CTRL_MEM_WRITE  = 9;
  localparam int unsigned CTRL_MEM_TO_REG = 8;
  localparam int unsigned CTRL_ALU_SRC    = 7;
  localparam int unsigned CTRL_REG_DST    = 6;
  localparam int unsigned CTRL_BRANCH     = 5;
  localparam int unsigned CTRL_JUMP       = 4;
  localparam int unsigned CTRL_ALU_LO     = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU_BNE lets EX tell bne from beq, since ctrl carries a single branch bit.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_BNE  = 4'd12;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: register-file bus between the decode logic and id_regfile.
//   wb_en/wb_addr/wb_data : write port (from WB stage)
//   ra1/ra2               : read addresses (rs, rt)
//   rd1/rd2               : read data
// master = decode side, slave = register file.
interface id_stage_if;
  import id_stage_pkg::*;

  logic                 wb_en;
  logic [REG_IDX_W-1:0] wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic [REG_IDX_W-1:0] ra1;
  logic [REG_IDX_W-1:0] ra2;
  logic [XLEN-1:0]      rd1;
  logic [XLEN-1:0]      rd2;

  modport master (
    output wb_en, wb_addr, wb_data, ra1, ra2,
    input  rd1, rd2
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, ra1, ra2,
    output rd1, rd2
  );
endinterface

// File: rtl/id_regfile.sv
// id_regfile: 32x32 register file, async active-low clear, 2 combinational
// read ports, 1 write port. $0 reads 0 and ignores writes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : id_stage_if.slave (write port + two read ports)
// Build option ID_WB_BYPASS_EN: a read of the register being written this
// cycle returns wb_data instead of the old contents.
module id_regfile
  import id_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  id_stage_if.slave       bus
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_en && (bus.wb_addr != '0)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    bus.rd1 = (bus.ra1 == '0) ? '0 : regs[bus.ra1];
    bus.rd2 = (bus.ra2 == '0) ? '0 : regs[bus.ra2];
`ifdef ID_WB_BYPASS_EN
    if (bus.wb_en && (bus.wb_addr != '0) && (bus.ra1 == bus.wb_addr)) bus.rd1 = bus.wb_data;
    if (bus.wb_en && (bus.wb_addr != '0) && (bus.ra2 == bus.wb_addr)) bus.rd2 = bus.wb_data;
`else
`endif
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS-subset instruction-decode stage.
//   CLK, RESET_N        : clock, asynchronous active-low reset
//   ifid                : {halt, pc, inst} from fetch
//   wb_en/wb_addr/wb_data : register writeback
//   ex_mem_read, ex_rt  : load currently in EX and its destination
//   flush               : squash the instruction in ID
//   stall_out           : combinational load-use stall to IF
//   idex                : registered ID/EX bundle
//   halted              : sticky, set once a halt has been consumed
// Build option ID_WB_BYPASS_EN (see id_regfile): write-before-read bypass.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [IFID_W-1:0]    ifid,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rt,
  input  logic                 flush,
  output logic                 stall_out,
  output logic [IDEX_W-1:0]    idex,
  output logic                 halted
);

  logic [XLEN-1:0]      inst;
  logic [XLEN-1:0]      pc;
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic [REG_IDX_W-1:0] rs;
  logic [REG_IDX_W-1:0] rt;
  logic [REG_IDX_W-1:0] rd;
  logic [4:0]           shamt;

  assign inst   = ifid[XLEN-1:0];
  assign pc     = ifid[PC_HI:PC_LO];
  assign opcode = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign shamt  = inst[10:6];
  assign funct  = inst[5:0];

  id_stage_if rf_bus ();

  assign rf_bus.wb_en   = wb_en;
  assign rf_bus.wb_addr = wb_addr;
  assign rf_bus.wb_data = wb_data;
  assign rf_bus.ra1     = rs;
  assign rf_bus.ra2     = rt;

  id_regfile u_regfile (
    .clk   (CLK),
    .rst_n (RESET_N),
    .bus   (rf_bus.slave)
  );

  logic [CTRL_W-1:0]    ctrl;
  logic [3:0]           alu_op;
  logic [XLEN-1:0]      imm;
  logic [REG_IDX_W-1:0] rd_sel;
  logic                 valid;

  always_comb begin
    ctrl   = '0;
    alu_op = ALU_ADD;
    imm    = '0;
    rd_sel = rd;
    valid  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_REG_DST]   = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_ADDU: alu_op = ALU_ADDU;
          FN_SUB:  alu_op = ALU_SUB;
          FN_SUBU: alu_op = ALU_SUBU;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  begin alu_op = ALU_SLL; imm = {27'b0, shamt}; end
          FN_SRL:  begin alu_op = ALU_SRL; imm = {27'b0, shamt}; end
          FN_SRA:  begin alu_op = ALU_SRA; imm = {27'b0, shamt}; end
          default: valid = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        imm = sign_ext16(inst[15:0]);
        alu_op = (opcode == OP_ADDI)  ? ALU_ADD  :
                 (opcode == OP_ADDIU) ? ALU_ADDU : ALU_SLT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        imm = {16'b0, inst[15:0]};
        alu_op = (opcode == OP_ANDI) ? ALU_AND :
                 (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LW: begin
        ctrl[CTRL_REG_WRITE]  = 1'b1;
        ctrl[CTRL_MEM_READ]   = 1'b1;
        ctrl[CTRL_MEM_TO_REG] = 1'b1;
        ctrl[CTRL_ALU_SRC]    = 1'b1;
        imm = sign_ext16(inst[15:0]);
      end
      OP_SW: begin
        ctrl[CTRL_MEM_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        imm = sign_ext16(inst[15:0]);
      end
      OP_BEQ, OP_BNE: begin
        ctrl[CTRL_BRANCH] = 1'b1;
        imm = sign_ext16(inst[15:0]);
        alu_op = (opcode == OP_BEQ) ? ALU_SUB : ALU_BNE;
      end
      OP_J: begin
        ctrl[CTRL_JUMP] = 1'b1;
        imm = {6'b0, inst[25:0]};
      end
      OP_JAL: begin
        ctrl[CTRL_JUMP]      = 1'b1;
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_REG_DST]   = 1'b1;
        imm    = {6'b0, inst[25:0]};
        rd_sel = 5'd31;
      end
      default: valid = 1'b0;
    endcase
    ctrl[CTRL_ALU_LO +: 4] = alu_op;
  end

  logic [IDEX_W-1:0] decoded;

  always_comb begin
    decoded = '0;
    if (valid) begin
      decoded[IDEX_PC_LO   +: XLEN]      = pc;
      decoded[IDEX_RSV_LO  +: XLEN]      = rf_bus.rd1;
      decoded[IDEX_RTV_LO  +: XLEN]      = rf_bus.rd2;
      decoded[IDEX_IMM_LO  +: XLEN]      = imm;
      decoded[IDEX_RS_LO   +: REG_IDX_W] = rs;
      decoded[IDEX_RT_LO   +: REG_IDX_W] = rt;
      decoded[IDEX_RD_LO   +: REG_IDX_W] = rd_sel;
      decoded[IDEX_CTRL_LO +: CTRL_W]    = ctrl;
    end
  end

  // rt only counts as a source for R-type, sw and branches; rs always does.
  logic rt_src;
  logic load_use;
  state_t state;

  assign rt_src   = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ)   || (opcode == OP_BNE);
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == rs) || (rt_src && (ex_rt == rt)));

  // Gated by RESET_N so the stall cannot leak out while reset is held.
  assign stall_out = RESET_N && (state == S_RUN) && !flush && load_use;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_RUN;
      idex   <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (flush || load_use) begin
            idex <= '0;
          end else if (ifid[HALT_BIT]) begin
            idex   <= {1'b1, {(IDEX_W-1){1'b0}}};
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            idex <= decoded;
          end
        end
        S_HALT: begin
          idex <= '0;
        end
        default: begin
          state <= S_RUN;
          idex  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic [64:0]  ifid;
  logic         ex_mem_read;
  logic [4:0]   ex_rt;
  logic         flush;
  logic         stall_out;
  logic [155:0] idex;
  logic         halted;

  id_stage_if bus ();

  always #5 CLK = ~CLK;

  id_stage dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .ifid        (ifid),
    .wb_en       (bus.wb_en),
    .wb_addr     (bus.wb_addr),
    .wb_data     (bus.wb_data),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .flush       (flush),
    .stall_out   (stall_out),
    .idex        (idex),
    .halted      (halted)
  );

  int checks   = 0;
  int failures = 0;

  typedef enum {M_BAD, M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR,
                M_SLT, M_SLL, M_SRL, M_SRA, M_ADDI, M_ADDIU, M_SLTI, M_ANDI,
                M_ORI, M_XORI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL} mn_t;

  // reference model state
  logic [31:0]  mregs [32];
  bit           mhalted;
  logic         act_stall, exp_stall;
  logic [155:0] exp_idex;
  logic [155:0] halt_word;

`ifdef ID_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [31:0] rtype(input logic [4:0] s, t, d, sh, input logic [5:0] fn);
    return {6'd0, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic mn_t mnem(input logic [31:0] i);
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h20: return M_ADD;  6'h21: return M_ADDU; 6'h22: return M_SUB;
        6'h23: return M_SUBU; 6'h24: return M_AND;  6'h25: return M_OR;
        6'h26: return M_XOR;  6'h27: return M_NOR;  6'h2A: return M_SLT;
        6'h00: return M_SLL;  6'h02: return M_SRL;  6'h03: return M_SRA;
        default: return M_BAD;
      endcase
    end
    case (i[31:26])
      6'h08: return M_ADDI; 6'h09: return M_ADDIU; 6'h0A: return M_SLTI;
      6'h0C: return M_ANDI; 6'h0D: return M_ORI;   6'h0E: return M_XORI;
      6'h23: return M_LW;   6'h2B: return M_SW;    6'h04: return M_BEQ;
      6'h05: return M_BNE;  6'h02: return M_J;     6'h03: return M_JAL;
      default: return M_BAD;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input mn_t m);
    case (m)
      M_ADDU, M_ADDIU: return 4'd1;
      M_SUB, M_BEQ:    return 4'd2;
      M_SUBU:          return 4'd3;
      M_AND, M_ANDI:   return 4'd4;
      M_OR, M_ORI:     return 4'd5;
      M_XOR, M_XORI:   return 4'd6;
      M_NOR:           return 4'd7;
      M_SLT, M_SLTI:   return 4'd8;
      M_SLL:           return 4'd9;
      M_SRL:           return 4'd10;
      M_SRA:           return 4'd11;
      M_BNE:           return 4'd12;
      default:         return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0]  a  = 5'($urandom);
    logic [4:0]  b  = 5'($urandom);
    logic [4:0]  c  = 5'($urandom);
    logic [4:0]  sh = 5'($urandom);
    logic [15:0] im = 16'($urandom);
    mn_t m;
    if ($urandom_range(0, 7) == 0) return $urandom;
    m = mn_t'($urandom_range(1, 24));
    case (m)
      M_ADD:   return rtype(a, b, c, sh, 6'h20);
      M_ADDU:  return rtype(a, b, c, sh, 6'h21);
      M_SUB:   return rtype(a, b, c, sh, 6'h22);
      M_SUBU:  return rtype(a, b, c, sh, 6'h23);
      M_AND:   return rtype(a, b, c, sh, 6'h24);
      M_OR:    return rtype(a, b, c, sh, 6'h25);
      M_XOR:   return rtype(a, b, c, sh, 6'h26);
      M_NOR:   return rtype(a, b, c, sh, 6'h27);
      M_SLT:   return rtype(a, b, c, sh, 6'h2A);
      M_SLL:   return rtype(a, b, c, sh, 6'h00);
      M_SRL:   return rtype(a, b, c, sh, 6'h02);
      M_SRA:   return rtype(a, b, c, sh, 6'h03);
      M_ADDI:  return itype(6'h08, a, b, im);
      M_ADDIU: return itype(6'h09, a, b, im);
      M_SLTI:  return itype(6'h0A, a, b, im);
      M_ANDI:  return itype(6'h0C, a, b, im);
      M_ORI:   return itype(6'h0D, a, b, im);
      M_XORI:  return itype(6'h0E, a, b, im);
      M_LW:    return itype(6'h23, a, b, im);
      M_SW:    return itype(6'h2B, a, b, im);
      M_BEQ:   return itype(6'h04, a, b, im);
      M_BNE:   return itype(6'h05, a, b, im);
      M_J:     return {6'h02, 26'($urandom)};
      default: return {6'h03, 26'($urandom)};
    endcase
  endfunction

  function automatic bit rt_is_source(input logic [31:0] i);
    mn_t m = mnem(i);
    return (i[31:26] == 6'h00) || (m == M_SW) || (m == M_BEQ) || (m == M_BNE);
  endfunction

  // Expected ID/EX word for an instruction, given the operand values it should see.
  function automatic logic [155:0] model_decode(input logic [64:0] f, input logic [31:0] a, b);
    logic [31:0] i = f[31:0];
    mn_t m = mnem(i);
    bit rw = 0, mr = 0, mw = 0, m2r = 0, as = 0, rdst = 0, br = 0, jp = 0;
    logic [31:0] im = '0;
    logic [4:0]  d  = i[15:11];
    if (m == M_BAD) return '0;
    if (i[31:26] == 6'h00) begin rw = 1; rdst = 1; end
    case (m)
      M_ADDI, M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI: begin rw = 1; as = 1; end
      M_LW:  begin rw = 1; mr = 1; m2r = 1; as = 1; end
      M_SW:  begin mw = 1; as = 1; end
      M_BEQ, M_BNE: br = 1;
      M_J:   jp = 1;
      M_JAL: begin jp = 1; rw = 1; rdst = 1; d = 5'd31; end
      default: ;
    endcase
    case (m)
      M_ADDI, M_ADDIU, M_SLTI, M_LW, M_SW, M_BEQ, M_BNE:
        im = 32'($signed(i[15:0]));
      M_ANDI, M_ORI, M_XORI: im = {16'h0000, i[15:0]};
      M_SLL, M_SRL, M_SRA:   im = {27'd0, i[10:6]};
      M_J, M_JAL:            im = {6'd0, i[25:0]};
      default: ;
    endcase
    return {1'b0, f[63:32], a, b, im, i[25:21], i[20:16], d,
            rw, mr, mw, m2r, as, rdst, br, jp, alu_code(m)};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (r == 0) return '0;
    if (BYPASS && we && wa == r) return wd;
    return mregs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mhalted = 0;
  endtask

  // Drives one cycle of inputs, samples stall_out before the edge, updates the
  // model and returns just after the edge with exp_* ready for comparison.
  task automatic cycle(input logic [64:0] f, input logic fl, input logic mr, input logic [4:0] ert,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic [4:0] s, t;
    bit hz;
    @(negedge CLK);
    ifid = f; flush = fl; ex_mem_read = mr; ex_rt = ert;
    bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
    #1 act_stall = stall_out;
    s  = f[25:21];
    t  = f[20:16];
    hz = mr && (ert != 0) && (ert == s || (rt_is_source(f[31:0]) && ert == t));
    exp_idex  = '0;
    exp_stall = 0;
    if (mhalted) begin
    end else if (fl) begin
    end else if (hz) begin
      exp_stall = 1;
    end else if (f[64]) begin
      exp_idex = halt_word;
      mhalted  = 1;
    end else begin
      exp_idex = model_decode(f, model_read(s, we, wa, wd), model_read(t, we, wa, wd));
    end
    if (we && wa != 0) mregs[wa] = wd;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    ifid = {1'b0, 32'h0, rtype(5'd2, 5'd6, 5'd5, 5'd0, 6'h22)};
    ex_mem_read = 1'b1; ex_rt = 5'd2; flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    #2;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_out); end
    checks++; if (idex !== '0) begin failures++; $display("FAIL reset_idex got=%h exp=0", idex); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_addi();
    cycle({1'b0, 32'h10, 32'h2001FFFB}, 0, 0, 0, 0, 0, 0);
    checks++; if (idex[58:27] !== 32'hFFFFFFFB) begin failures++; $display("FAIL addi_imm got=%h exp=fffffffb", idex[58:27]); end
    checks++; if (idex[21:17] !== 5'd1) begin failures++; $display("FAIL addi_rt got=%0d exp=1", idex[21:17]); end
    checks++; if (idex[11] !== 1'b1 || idex[7] !== 1'b1) begin failures++; $display("FAIL addi_ctrl got rw=%b as=%b exp=1,1", idex[11], idex[7]); end
    checks++; if (idex[154:123] !== 32'h10) begin failures++; $display("FAIL addi_pc got=%h exp=10", idex[154:123]); end
    checks++; if (idex !== exp_idex) begin failures++; $display("FAIL addi_idex got=%h exp=%h", idex, exp_idex); end
  endtask

  task automatic test_bypass();
    logic [64:0] f;
    logic [31:0] first_exp;
    f = {1'b0, 32'h14, rtype(5'd3, 5'd0, 5'd4, 5'd0, 6'h20)};
    first_exp = BYPASS ? 32'hDEADBEEF : 32'h0;
    cycle(f, 0, 0, 0, 1, 5'd3, 32'hDEADBEEF);
    checks++; if (idex[122:91] !== first_exp) begin failures++; $display("FAIL bypass_same got=%h exp=%h", idex[122:91], first_exp); end
    checks++; if (idex !== exp_idex) begin failures++; $display("FAIL bypass_idex got=%h exp=%h", idex, exp_idex); end
    cycle(f, 0, 0, 0, 0, 0, 0);
    checks++; if (idex[122:91] !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_next got=%h exp=deadbeef", idex[122:91]); end
  endtask

  task automatic test_hazard();
    logic [31:0] insts [4];
    logic [4:0]  erts  [4];
    logic        stalls[4];
    insts[0] = rtype(5'd2, 5'd6, 5'd5, 5'd0, 6'h22); erts[0] = 5'd2; stalls[0] = 1; // rs match
    insts[1] = itype(6'h2B, 5'd9, 5'd7, 16'h4);      erts[1] = 5'd7; stalls[1] = 1; // sw rt source
    insts[2] = itype(6'h08, 5'd9, 5'd7, 16'h1);      erts[2] = 5'd7; stalls[2] = 0; // addi rt is dest
    insts[3] = rtype(5'd0, 5'd0, 5'd1, 5'd0, 6'h20); erts[3] = 5'd0; stalls[3] = 0; // $0 never stalls
    for (int k = 0; k < 4; k++) begin
      cycle({1'b0, 32'h20, insts[k]}, 0, 1, erts[k], 0, 0, 0);
      checks++; if (act_stall !== stalls[k]) begin failures++; $display("FAIL hazard_stall[%0d] got=%b exp=%b", k, act_stall, stalls[k]); end
      checks++; if (idex !== exp_idex) begin failures++; $display("FAIL hazard_idex[%0d] got=%h exp=%h", k, idex, exp_idex); end
    end
    cycle({1'b0, 32'h20, insts[0]}, 0, 0, 5'd2, 0, 0, 0);
    checks++; if (act_stall !== 1'b0) begin failures++; $display("FAIL hazard_release_stall got=%b exp=0", act_stall); end
    checks++; if (idex[11:0] !== 12'b1000_0100_0010) begin failures++; $display("FAIL hazard_release_ctrl got=%b exp=100001000010", idex[11:0]); end
  endtask

  task automatic test_flush();
    logic [64:0] f;
    f = {1'b0, 32'h24, rtype(5'd2, 5'd6, 5'd5, 5'd0, 6'h22)};
    cycle(f, 1, 1, 5'd2, 0, 0, 0);
    checks++; if (act_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", act_stall); end
    checks++; if (idex !== '0) begin failures++; $display("FAIL flush_idex got=%h exp=0", idex); end
    f = {1'b0, 32'h28, rtype(5'd0, 5'd0, 5'd1, 5'd0, 6'h20)};
    cycle(f, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    checks++; if (idex[122:91] !== 32'h0) begin failures++; $display("FAIL r0_same got=%h exp=0", idex[122:91]); end
    cycle(f, 0, 0, 0, 0, 0, 0);
    checks++; if (idex[122:91] !== 32'h0 || idex[90:59] !== 32'h0) begin failures++; $display("FAIL r0_read got=%h/%h exp=0/0", idex[122:91], idex[90:59]); end
  endtask

  task automatic test_random();
    logic [31:0] i;
    logic [4:0]  ert;
    int          k;
    for (int r = 1; r < 32; r++)
      cycle({1'b0, 32'($urandom), rand_inst()}, 0, 0, 0, 1, 5'(r), $urandom);
    for (int n = 0; n < 400; n++) begin
      i = rand_inst();
      k = $urandom_range(0, 2);
      ert = (k == 0) ? i[25:21] : (k == 1) ? i[20:16] : 5'($urandom);
      cycle({1'b0, 32'($urandom), i}, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
            ert, 1'($urandom), 5'($urandom), $urandom);
      checks++; if (act_stall !== exp_stall) begin failures++; $display("FAIL rand_stall[%0d] inst=%h got=%b exp=%b", n, i, act_stall, exp_stall); end
      checks++; if (idex !== exp_idex) begin failures++; $display("FAIL rand_idex[%0d] inst=%h got=%h exp=%h", n, i, idex, exp_idex); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rand_halted[%0d] got=%b exp=0", n, halted); end
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [64:0] f;
    f = {1'b0, 32'h30, rtype(5'd2, 5'd6, 5'd5, 5'd0, 6'h22)};
    cycle(f, 0, 1, 5'd2, 0, 0, 0);
    checks++; if (act_stall !== 1'b1) begin failures++; $display("FAIL midstall_pre got=%b exp=1", act_stall); end
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL midstall_reset got=%b exp=0", stall_out); end
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    cycle(f, 0, 0, 0, 0, 0, 0);
    checks++; if (idex !== exp_idex || idex[122:91] !== 32'h0) begin failures++; $display("FAIL midstall_after got=%h exp=%h", idex, exp_idex); end
  endtask

  task automatic test_halt();
    logic [64:0] hb;
    hb = 65'h1_00000020_FFFFFFFF;
    cycle({1'b0, 32'h1C, itype(6'h08, 5'd0, 5'd5, 16'h0)}, 0, 0, 0, 1, 5'd5, 32'h12345678);
    cycle(hb, 1, 0, 0, 0, 0, 0);
    checks++; if (idex !== '0 || halted !== 1'b0) begin failures++; $display("FAIL halt_flushed idex=%h halted=%b exp=0,0", idex, halted); end
    cycle(hb, 0, 0, 0, 0, 0, 0);
    checks++; if (idex !== halt_word) begin failures++; $display("FAIL halt_idex got=%h exp=%h", idex, halt_word); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
    for (int n = 0; n < 20; n++) begin
      cycle({1'($urandom), 32'($urandom), rand_inst()}, 1'($urandom), 1'($urandom), 5'($urandom),
            1'($urandom), 5'($urandom), $urandom);
      checks++; if (idex !== '0 || act_stall !== 1'b0) begin failures++; $display("FAIL halt_hold[%0d] idex=%h stall=%b exp=0,0", n, idex, act_stall); end
      checks++; if (halted !== 1'b1 || exp_idex !== idex) begin failures++; $display("FAIL halt_sticky[%0d] halted=%b exp=1", n, halted); end
    end
    @(negedge CLK);
    RESET_N = 1'b0;
    ex_mem_read = 1'b1; ex_rt = 5'd5; ifid = {1'b0, 32'h40, rtype(5'd5, 5'd0, 5'd1, 5'd0, 6'h20)};
    #1;
    checks++; if (halted !== 1'b0 || idex !== '0 || stall_out !== 1'b0) begin failures++; $display("FAIL halt_reset halted=%b idex=%h stall=%b exp=0,0,0", halted, idex, stall_out); end
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    cycle({1'b0, 32'h40, rtype(5'd5, 5'd0, 5'd1, 5'd0, 6'h20)}, 0, 0, 0, 0, 0, 0);
    checks++; if (idex[122:91] !== 32'h0 || idex[11] !== 1'b1) begin failures++; $display("FAIL halt_regs_cleared rs_val=%h rw=%b exp=0,1", idex[122:91], idex[11]); end
    checks++; if (idex !== exp_idex) begin failures++; $display("FAIL halt_resume got=%h exp=%h", idex, exp_idex); end
  endtask

  initial begin
    halt_word = '0;
    halt_word[155] = 1'b1;
    test_reset();
    test_addi();
    test_bypass();
    test_hazard();
    test_flush();
    test_random();
    test_reset_mid_stall();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage; sits directly downstream of the fetch stage and consumes its 65-bit IF/ID bundle: [64] halt flag, [63:32] PC, [31:0] instruction.
- Holds the 32x32 register file and decodes the MIPS-subset instruction into control bits.
- Detects load-use hazards and produces the registered ID/EX bundle for the execute stage.

Parameters:
- IDEX_W, 156: ID/EX bundle width. Fixed by the package layout; not user-tunable.
- NUM_REGS, 32: register file depth. Register index width is 5.

Ports:
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous, active-low reset
- ifid  input  65  IF/ID bundle {halt, pc[31:0], inst[31:0]}
- wb_en  input  1  writeback enable from WB stage
- wb_addr  input  5  writeback register index
- wb_data  input  32  writeback data
- ex_mem_read  input  1  instruction currently in EX is a load
- ex_rt  input  5  destination register of that load
- flush  input  1  taken branch/jump resolved in EX; squash the ID instruction
- stall_out  output  1  tells IF to hold PC and the IF/ID bundle
- idex  output  IDEX_W  registered ID/EX bundle
- halted  output  1  sticky; the stage has consumed a halt

Behaviour:
- Reset (async, RESET_N low):
  - idex = 0, halted = 0, all 32 registers = 0, state = RUN.
  - stall_out is combinational and evaluates to 0 under reset.
- ID/EX layout, MSB to LSB:
  - halt(1), pc(32), rs_val(32), rt_val(32), imm(32), rs(5), rt(5), rd(5), ctrl(12).
  - ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, jump, alu_op[3:0]}.
- Latency: idex updates on the CLK edge after ifid is presented (1 cycle).
- Register file:
  - Written on the CLK rising edge when wb_en=1 and wb_addr!=0; writes to $0 are dropped.
  - Reads are combinational; $0 always reads 0.
- Decode:
  - R-type (opcode 0) funct: add, addu, sub, subu, and, or, xor, nor, slt, sll, srl, sra.
  - I-type: addi, addiu, slti, andi, ori, xori, lw, sw, beq, bne. J-type: j, jal.
  - Any other encoding decodes as a bubble (ctrl=0).
- Immediate generation:
  - Sign-extended for addi, addiu, slti, lw, sw, beq, bne.
  - Zero-extended for andi, ori, xori.
  - Shifts: imm = {27'b0, shamt}. Jumps: imm = {6'b0, target[25:0]}.
  - jal: rd forced to 31, reg_write=1.
- Bubble: idex with ctrl=0, halt=0, all other fields 0.
- Load-use hazard:
  - Condition: ex_mem_read=1 and ex_rt!=0 and (ex_rt==rs, or ex_rt==rt with rt used as a source: R-type, sw, beq, bne).
  - Response: stall_out=1 (combinational), idex loads a bubble, and the same ifid is re-decoded next cycle.
- Flush:
  - flush=1 → idex loads a bubble and stall_out=0.
  - Flush takes priority over stall and over halt; a flushed halt is ignored.
- State machine RUN/HALT:
  - In RUN, when ifid[64]=1 with no flush and no stall: idex loads a bubble with halt=1, halted←1, state←HALT.
  - In HALT: idex holds bubbles (halt=0), stall_out=0, and ifid, flush and hazard inputs are ignored.
  - Register writeback continues in HALT so in-flight instructions retire.
  - Only reset leaves HALT.
- Reset mid-stall or mid-halt: everything returns to the reset values above; no residual stall.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: a same-cycle read of wb_addr (non-zero) with wb_en=1 returns wb_data (write-before-read).
- Undefined: a same-cycle read returns the old register value; the hazard logic is unchanged.

Decomposition:
- Shared package holds:
  - Opcode/funct constants and the ALU_* alu_op encodings.
  - The ctrl bit positions and the IDEX field offsets/IDEX_W.
  - IFID field offsets (HALT_BIT=64, PC_HI=63, PC_LO=32).
- Natural sub-module: id_regfile (32x32, async-reset clear, 2 read ports, 1 write port, bypass under ID_WB_BYPASS_EN).
- Decode and hazard logic stay in id_stage.

Test Plan:
- Reset then addi $1,$0,-5 (0x2001FFFB) at pc=0x10 → next edge: idex.imm=0xFFFFFFFB, rt=1, reg_write=1, alu_src=1, pc=0x10.
- wb_en=1, wb_addr=3, wb_data=0xDEADBEEF concurrent with ifid=add $4,$3,$0 → with ID_WB_BYPASS_EN, rs_val=0xDEADBEEF; without it, rs_val=0. Next cycle both builds read 0xDEADBEEF.
- ex_mem_read=1, ex_rt=2, ifid=sub $5,$2,$6 → stall_out=1 and idex is a bubble. Drop ex_mem_read → normal decode.
- Same hazard with flush=1 → stall_out=0 and idex is a bubble. Write $0 via WB → reads remain 0.
- ifid=0x1_00000020_FFFFFFFF → idex.halt=1, halted=1. Subsequent ifid values ignored (bubbles); pulse RESET_N low → halted=0, idex=0, registers cleared.
